// File: rtl/ltc2311_capture_engine_if.sv
// ADC pin and FIFO write-port bundle for the LTC2311-16 capture engine.
// master = capture engine, slave = ADC model / FIFO controller side.
interface ltc2311_capture_engine_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  adc_cnv;
    logic                  adc_sck;
    logic                  adc_sdo;
    logic [DATA_WIDTH-1:0] sample_data;
    logic                  write_increment;
    logic                  fifo_full;

    modport master (
        output adc_cnv, adc_sck, sample_data, write_increment,
        input  adc_sdo, fifo_full
    );

    modport slave (
        input  adc_cnv, adc_sck, sample_data, write_increment,
        output adc_sdo, fifo_full
    );
endinterface

// File: rtl/ltc2311_capture_engine.sv
// LTC2311-16 capture engine: timed CNV, SCK/SDO deserialiser, FIFO push with overrun counting.
// Optional macro LTC2311_TEST_PATTERN_EN replaces stored samples with an incrementing counter.
module ltc2311_capture_engine #(
    parameter int DATA_WIDTH        = 16,
    parameter int SAMPLE_PERIOD     = 100,
    parameter int CNV_HIGH_CYCLES   = 3,
    parameter int CONVERSION_CYCLES = 45,
    parameter int SCK_HALF_PERIOD   = 1,
    parameter int OVERRUN_WIDTH     = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     clear,
    ltc2311_capture_engine_if.master bus,
    output logic                     busy,
    output logic                     overrun,
    output logic [OVERRUN_WIDTH-1:0] overrun_count
);
    localparam int TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int CNV_W = (CONVERSION_CYCLES > 1) ? $clog2(CONVERSION_CYCLES) : 1;
    localparam int PH_W  = (SCK_HALF_PERIOD > 1) ? $clog2(SCK_HALF_PERIOD) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST      = TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [CNV_W-1:0] CONV_LAST     = CNV_W'(CONVERSION_CYCLES - 1);
    localparam logic [CNV_W-1:0] CNV_HIGH_LAST = CNV_W'(CNV_HIGH_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_LAST       = PH_W'(SCK_HALF_PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_SHIFT,
        S_STORE
    } state_t;

    state_t                   r_state;
    logic [TMR_W-1:0]         r_timer;
    logic [CNV_W-1:0]         r_conv_cnt;
    logic [PH_W-1:0]          r_phase_cnt;
    logic [BIT_W-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0]    r_shift;
    logic [DATA_WIDTH-1:0]    r_sample_data;
    logic                     r_cnv;
    logic                     r_sck;
    logic                     r_busy;
    logic                     r_push_pend;
    logic                     r_write_increment;
    logic                     r_overrun;
    logic [OVERRUN_WIDTH-1:0] r_overrun_count;
`ifdef LTC2311_TEST_PATTERN_EN
    logic [DATA_WIDTH-1:0]    r_pattern;
`endif
    logic                     w_tick;

    assign w_tick = enable && (r_timer == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if (clear || !enable || (r_timer == TMR_LAST)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Strobe lags STORE by one extra cycle so sample_data is already stable when it rises.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= S_IDLE;
            r_conv_cnt        <= '0;
            r_phase_cnt       <= '0;
            r_bit_cnt         <= '0;
            r_shift           <= '0;
            r_sample_data     <= '0;
            r_cnv             <= 1'b0;
            r_sck             <= 1'b0;
            r_busy            <= 1'b0;
            r_push_pend       <= 1'b0;
            r_write_increment <= 1'b0;
            r_overrun         <= 1'b0;
            r_overrun_count   <= '0;
`ifdef LTC2311_TEST_PATTERN_EN
            r_pattern         <= '0;
`endif
        end else if (clear) begin
            r_state           <= S_IDLE;
            r_conv_cnt        <= '0;
            r_phase_cnt       <= '0;
            r_bit_cnt         <= '0;
            r_shift           <= '0;
            r_sample_data     <= '0;
            r_cnv             <= 1'b0;
            r_sck             <= 1'b0;
            r_busy            <= 1'b0;
            r_push_pend       <= 1'b0;
            r_write_increment <= 1'b0;
            r_overrun         <= 1'b0;
            r_overrun_count   <= '0;
`ifdef LTC2311_TEST_PATTERN_EN
            r_pattern         <= '0;
`endif
        end else begin
            r_write_increment <= r_push_pend;
            r_push_pend       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state    <= S_CONVERT;
                        r_cnv      <= 1'b1;
                        r_busy     <= 1'b1;
                        r_conv_cnt <= '0;
                    end
                end
                S_CONVERT: begin
                    r_cnv <= (r_conv_cnt < CNV_HIGH_LAST);
                    if (r_conv_cnt == CONV_LAST) begin
                        r_state     <= S_SHIFT;
                        r_phase_cnt <= '0;
                        r_bit_cnt   <= '0;
                        r_sck       <= 1'b0;
                    end else begin
                        r_conv_cnt <= r_conv_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (r_phase_cnt == PH_LAST) begin
                        r_phase_cnt <= '0;
                        if (!r_sck) begin
                            r_sck <= 1'b1;
                        end else begin
                            r_sck   <= 1'b0;
                            r_shift <= {r_shift[DATA_WIDTH-2:0], bus.adc_sdo};
                            if (r_bit_cnt == BIT_LAST) begin
                                r_state <= S_STORE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        r_phase_cnt <= r_phase_cnt + 1'b1;
                    end
                end
                S_STORE: begin
`ifdef LTC2311_TEST_PATTERN_EN
                    r_sample_data <= r_pattern;
                    r_pattern     <= r_pattern + 1'b1;
`else
                    r_sample_data <= r_shift;
`endif
                    if (bus.fifo_full) begin
                        r_overrun <= 1'b1;
                        if (r_overrun_count != '1) begin
                            r_overrun_count <= r_overrun_count + 1'b1;
                        end
                    end else begin
                        r_push_pend <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.adc_cnv         = r_cnv;
    assign bus.adc_sck         = r_sck;
    assign bus.sample_data     = r_sample_data;
    assign bus.write_increment = r_write_increment;
    assign busy                = r_busy;
    assign overrun             = r_overrun;
    assign overrun_count       = r_overrun_count;
endmodule

// File: tb/tb_ltc2311_capture_engine.sv
// Scoreboard bench for ltc2311_capture_engine: ADC SDO model, latency/period checks, overrun, abort paths.
module tb_ltc2311_capture_engine;
    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0] data;
        int            rise;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n, enable, clear, en2;
    logic       busy, overrun, busy2, overrun2;
    logic [7:0] overrun_count;
    logic [1:0] overrun_count2;
    logic       sdo_bit, full_drv;

    always #5 clock = ~clock;

    ltc2311_capture_engine_if #(.DATA_WIDTH(DW)) bus ();
    ltc2311_capture_engine_if #(.DATA_WIDTH(DW)) bus2 ();

    assign bus.adc_sdo    = sdo_bit;
    assign bus.fifo_full  = full_drv;
    assign bus2.adc_sdo   = 1'b0;
    assign bus2.fifo_full = 1'b1;

    ltc2311_capture_engine #(
        .DATA_WIDTH(DW), .SAMPLE_PERIOD(100), .CNV_HIGH_CYCLES(3),
        .CONVERSION_CYCLES(45), .SCK_HALF_PERIOD(1), .OVERRUN_WIDTH(8)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
        .bus(bus), .busy(busy), .overrun(overrun), .overrun_count(overrun_count)
    );

    ltc2311_capture_engine #(
        .DATA_WIDTH(DW), .SAMPLE_PERIOD(100), .CNV_HIGH_CYCLES(3),
        .CONVERSION_CYCLES(45), .SCK_HALF_PERIOD(1), .OVERRUN_WIDTH(2)
    ) dut_sat (
        .clock(clock), .reset_n(reset_n), .enable(en2), .clear(1'b0),
        .bus(bus2), .busy(busy2), .overrun(overrun2), .overrun_count(overrun_count2)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    exp_t          sb[$];
    int            cyc = 0;
    int            rise_cyc = 0, last_rise = 0, cnv_hi = 0, sck_cnt = 0, bit_idx = 0;
    int            rise_count = 0, strobe_count = 0, exp_ovf = 0;
    bit            period_ok = 0, released = 0, dut2_done = 0;
    logic          prev_cnv = 0, prev_sck = 0, prev_wi = 0;
    logic [DW-1:0] adc_word = '0, next_word = 16'hA5C3, pat_model = '0;

    always @(posedge clock) cyc++;

    // Bench-side ADC model and output monitor, all sampled on the falling edge.
    always @(negedge clock) begin
        exp_t e;
        if (bus.adc_cnv && !prev_cnv) begin
            if (period_ok) check("cnv_period", cyc - last_rise, 100);
            period_ok = 1;
            last_rise = cyc;
            rise_cyc  = cyc;
            cnv_hi    = 0;
            sck_cnt   = 0;
            bit_idx   = 0;
            rise_count++;
            adc_word  = next_word;
            next_word = 16'($urandom);
            if (full_drv) begin
                if (exp_ovf < 255) exp_ovf++;
            end else begin
`ifdef LTC2311_TEST_PATTERN_EN
                sb.push_back('{data: pat_model, rise: cyc});
`else
                sb.push_back('{data: adc_word, rise: cyc});
`endif
            end
            pat_model = pat_model + 1'b1;
        end
        if (bus.adc_cnv) cnv_hi++;
        if (!bus.adc_cnv && prev_cnv) check("cnv_high_cycles", cnv_hi, 3);
        if (bus.adc_sck && !prev_sck) begin
            sck_cnt++;
            if (sck_cnt == 1) check("first_sck_offset", cyc - rise_cyc, 46);
        end
        if (!bus.adc_sck && prev_sck) bit_idx++;
`ifdef LTC2311_TEST_PATTERN_EN
        sdo_bit = 1'b1;
`else
        sdo_bit = (bit_idx < DW) ? adc_word[DW-1-bit_idx] : 1'b0;
`endif
        if (bus.write_increment) begin
            strobe_count++;
            check("wi_back_to_back", prev_wi, 0);
            if (sb.size() == 0) begin
                check("spurious_wi", bus.write_increment, 0);
            end else begin
                e = sb.pop_front();
                check("sample_data", bus.sample_data, e.data);
                check("strobe_latency", cyc - e.rise, 79);
                check("sck_pulses", sck_cnt, 16);
            end
        end
        prev_cnv = bus.adc_cnv;
        prev_sck = bus.adc_sck;
        prev_wi  = bus.write_increment;
    end

    task automatic abort_model();
        sb.delete();
        pat_model = '0;
        period_ok = 0;
        exp_ovf   = 0;
    endtask

    task automatic wait_rises(input int target);
        for (int i = 0; i < 400 && rise_count < target; i++) begin
            @(negedge clock); #1;
        end
        if (rise_count < target) check("timeout_cnv", rise_count, target);
    endtask

    task automatic wait_strobes(input int target);
        for (int i = 0; i < 400 && strobe_count < target; i++) begin
            @(negedge clock); #1;
        end
        if (strobe_count < target) check("timeout_strobe", strobe_count, target);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) begin
            @(negedge clock); #1;
        end
        if (busy) check("timeout_idle", busy, 0);
    endtask

    initial begin
        wait (released);
        repeat (200) @(negedge clock);
        check("sat_count_2", overrun_count2, 2);
        check("sat_overrun", overrun2, 1);
        repeat (300) @(negedge clock);
        check("sat_count_3", overrun_count2, 3);
        dut2_done = 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r0, s0;
        reset_n  = 1'b0;
        enable   = 1'b0;
        clear    = 1'b0;
        en2      = 1'b0;
        full_drv = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_cnv", bus.adc_cnv, 0);
        check("rst_sck", bus.adc_sck, 0);
        check("rst_wi", bus.write_increment, 0);
        check("rst_data", bus.sample_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_ovf_count", overrun_count, 0);

        reset_n  = 1'b1;
        enable   = 1'b1;
        en2      = 1'b1;
        released = 1;
        wait_strobes(1);

        full_drv = 1'b1;
        r0 = rise_count;
        wait_rises(r0 + 3);
        wait_idle();
        full_drv = 1'b0;
        check("overrun_set", overrun, 1);
        check("overrun_count", overrun_count, exp_ovf);
        wait_strobes(2);
        check("overrun_sticky", overrun, 1);

        r0 = rise_count;
        wait_rises(r0 + 1);
        repeat (10) @(negedge clock);
        clear = 1'b1;
        abort_model();
        @(negedge clock);
        check("clr_busy", busy, 0);
        check("clr_cnv", bus.adc_cnv, 0);
        check("clr_overrun", overrun, 0);
        check("clr_ovf_count", overrun_count, 0);
        check("clr_data", bus.sample_data, 0);
        clear = 1'b0;
        @(negedge clock);
        check("cnv_after_clear", bus.adc_cnv, 1);
        s0 = strobe_count;
        wait_strobes(s0 + 1);

        wait (dut2_done);
        r0 = rise_count;
        wait_rises(r0 + 1);
        repeat (60) @(negedge clock);
        reset_n = 1'b0;
        abort_model();
        #1;
        check("arst_sck", bus.adc_sck, 0);
        check("arst_busy", busy, 0);
        check("arst_data", bus.sample_data, 0);
        check("arst_cnv", bus.adc_cnv, 0);
        s0 = strobe_count;
        repeat (3) @(negedge clock);
        check("arst_no_strobe", strobe_count, s0);
        reset_n = 1'b1;
        @(negedge clock);
        check("cnv_after_reset", bus.adc_cnv, 1);
        wait_strobes(s0 + 3);

        r0 = rise_count;
        s0 = strobe_count;
        wait_rises(r0 + 1);
        repeat (10) @(negedge clock);
        enable = 1'b0;
        wait_strobes(s0 + 1);
        repeat (250) @(negedge clock);
        check("no_tick_when_disabled", rise_count, r0 + 1);
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
